// File: rtl/register_file_pkg.sv
// Shared constants for the architectural register file and its read ports.
package register_file_pkg;

  localparam int ROB_WIDTH_DEF = 4;
  localparam int REG_COUNT = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  function automatic logic is_zero(
    input logic [REG_ADDR_W-1:0] a
  );
    return a == ZERO_REG;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One read port: x0 forcing and the optional same-cycle commit bypass
// (enabled by REGFILE_COMMIT_BYPASS_EN).
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic                  reg_busy_i,
  input  logic [ROB_WIDTH-1:0]  reg_tag_i,
  input  logic [XLEN-1:0]       reg_val_i,
  input  logic                  cmt_en_i,
  input  logic [REG_ADDR_W-1:0] cmt_dest_i,
  input  logic [ROB_WIDTH-1:0]  cmt_id_i,
  input  logic [XLEN-1:0]       cmt_val_i,
  input  logic                  ren_flag_i,
  input  logic [REG_ADDR_W-1:0] ren_dest_i,
  output logic                  busy_o,
  output logic [ROB_WIDTH-1:0]  tag_o,
  output logic [XLEN-1:0]       val_o
);

`ifdef REGFILE_COMMIT_BYPASS_EN
  logic hit;
  assign hit = cmt_en_i
            && (addr_i == cmt_dest_i)
            && (reg_tag_i == cmt_id_i)
            && !(ren_flag_i && (ren_dest_i == addr_i));
`else
  logic hit;
  logic unused_bypass;
  assign hit = 1'b0;
  assign unused_bypass = ^{cmt_en_i, cmt_dest_i, cmt_id_i,
                           cmt_val_i, ren_flag_i, ren_dest_i};
`endif

  always_comb begin
    busy_o = reg_busy_i;
    tag_o  = reg_tag_i;
    val_o  = reg_val_i;
    if (is_zero(addr_i)) begin
      busy_o = 1'b0;
      tag_o  = '0;
      val_o  = '0;
    end else if (hit) begin
      busy_o = 1'b0;
      val_o  = cmt_val_i;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Optional same-cycle commit bypass: define REGFILE_COMMIT_BYPASS_EN.
module register_file
  import register_file_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  readyIn,
  input  logic                  clear,
  input  logic                  renameFlag,
  input  logic [REG_ADDR_W-1:0] renameDest,
  input  logic [ROB_WIDTH-1:0]  renameRobId,
  input  logic                  rfFlag,
  input  logic [ROB_WIDTH-1:0]  rfRobId,
  input  logic [REG_ADDR_W-1:0] rfDest,
  input  logic [XLEN-1:0]       rfValue,
  input  logic [REG_ADDR_W-1:0] rs1Addr,
  input  logic [REG_ADDR_W-1:0] rs2Addr,
  output logic                  rs1Busy,
  output logic                  rs2Busy,
  output logic [ROB_WIDTH-1:0]  rs1RobId,
  output logic [ROB_WIDTH-1:0]  rs2RobId,
  output logic [XLEN-1:0]       rs1Val,
  output logic [XLEN-1:0]       rs2Val
);

  logic [XLEN-1:0]      value_q [REG_COUNT];
  logic [XLEN-1:0]      value_d [REG_COUNT];
  logic [ROB_WIDTH-1:0] tag_q   [REG_COUNT];
  logic [ROB_WIDTH-1:0] tag_d   [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  logic cmt_en;
  logic ren_en;
  logic byp_en;

  assign cmt_en = rfFlag && readyIn && !is_zero(rfDest);
  assign ren_en = renameFlag && readyIn && !clear
               && !is_zero(renameDest);
  // reset must win over a bypassed commit so reads show 0 at once
  assign byp_en = rfFlag && readyIn && resetIn;

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (cmt_en) begin
      value_d[rfDest] = rfValue;
      if (tag_q[rfDest] == rfRobId) begin
        busy_d[rfDest] = 1'b0;
      end
    end
    if (readyIn && clear) begin
      busy_d = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        tag_d[i] = '0;
      end
    end else if (ren_en) begin
      busy_d[renameDest] = 1'b1;
      tag_d[renameDest]  = renameRobId;
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      busy_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 1; i < REG_COUNT; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  register_file_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs1 (
    .addr_i     (rs1Addr),
    .reg_busy_i (busy_q[rs1Addr]),
    .reg_tag_i  (tag_q[rs1Addr]),
    .reg_val_i  (value_q[rs1Addr]),
    .cmt_en_i   (byp_en),
    .cmt_dest_i (rfDest),
    .cmt_id_i   (rfRobId),
    .cmt_val_i  (rfValue),
    .ren_flag_i (renameFlag),
    .ren_dest_i (renameDest),
    .busy_o     (rs1Busy),
    .tag_o      (rs1RobId),
    .val_o      (rs1Val)
  );

  register_file_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs2 (
    .addr_i     (rs2Addr),
    .reg_busy_i (busy_q[rs2Addr]),
    .reg_tag_i  (tag_q[rs2Addr]),
    .reg_val_i  (value_q[rs2Addr]),
    .cmt_en_i   (byp_en),
    .cmt_dest_i (rfDest),
    .cmt_id_i   (rfRobId),
    .cmt_val_i  (rfValue),
    .ren_flag_i (renameFlag),
    .ren_dest_i (renameDest),
    .busy_o     (rs2Busy),
    .tag_o      (rs2RobId),
    .val_o      (rs2Val)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed + random bench for register_file against an array-based model.
module tb_register_file;

  localparam int RW = 4;

  logic          clockIn;
  logic          resetIn;
  logic          readyIn;
  logic          clear;
  logic          renameFlag;
  logic [4:0]    renameDest;
  logic [RW-1:0] renameRobId;
  logic          rfFlag;
  logic [RW-1:0] rfRobId;
  logic [4:0]    rfDest;
  logic [31:0]   rfValue;
  logic [4:0]    rs1Addr;
  logic [4:0]    rs2Addr;
  logic          rs1Busy;
  logic          rs2Busy;
  logic [RW-1:0] rs1RobId;
  logic [RW-1:0] rs2RobId;
  logic [31:0]   rs1Val;
  logic [31:0]   rs2Val;

  int n_assert = 0;
  int n_fail = 0;

  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RW-1:0] m_tag  [32];

  register_file #(.ROB_WIDTH(RW)) dut (
    .clockIn     (clockIn),
    .resetIn     (resetIn),
    .readyIn     (readyIn),
    .clear       (clear),
    .renameFlag  (renameFlag),
    .renameDest  (renameDest),
    .renameRobId (renameRobId),
    .rfFlag      (rfFlag),
    .rfRobId     (rfRobId),
    .rfDest      (rfDest),
    .rfValue     (rfValue),
    .rs1Addr     (rs1Addr),
    .rs2Addr     (rs2Addr),
    .rs1Busy     (rs1Busy),
    .rs2Busy     (rs2Busy),
    .rs1RobId    (rs1RobId),
    .rs2RobId    (rs2RobId),
    .rs1Val      (rs1Val),
    .rs2Val      (rs2Val)
  );

  initial begin
    clockIn = 1'b0;
    forever #5 clockIn = ~clockIn;
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  task automatic model_edge();
    logic [RW-1:0] old_tag;
    if (!resetIn || !readyIn) return;
    if (rfFlag && rfDest != 0) begin
      old_tag = m_tag[rfDest];
      m_val[rfDest] = rfValue;
      if (old_tag == rfRobId) m_busy[rfDest] = 1'b0;
    end
    if (clear) begin
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 1'b0;
        m_tag[i]  = '0;
      end
    end else if (renameFlag && renameDest != 0) begin
      m_busy[renameDest] = 1'b1;
      m_tag[renameDest]  = renameRobId;
    end
  endtask

  task automatic exp_read(
    input  logic [4:0]    a,
    output logic          b,
    output logic [RW-1:0] t,
    output logic [31:0]   v
  );
    b = m_busy[a];
    t = m_tag[a];
    v = m_val[a];
    if (a == 0) begin
      b = 1'b0;
      t = '0;
      v = '0;
    end
`ifdef REGFILE_COMMIT_BYPASS_EN
    else if (resetIn && readyIn && rfFlag && rfDest == a
             && m_tag[a] == rfRobId
             && !(renameFlag && renameDest == a)) begin
      b = 1'b0;
      v = rfValue;
    end
`endif
  endtask

  task automatic check1(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag);
    logic          b;
    logic [RW-1:0] t;
    logic [31:0]   v;
    #1;
    exp_read(rs1Addr, b, t, v);
    check1({tag, ".rs1Busy"}, 32'(rs1Busy), 32'(b));
    check1({tag, ".rs1RobId"}, 32'(rs1RobId), 32'(t));
    check1({tag, ".rs1Val"}, rs1Val, v);
    exp_read(rs2Addr, b, t, v);
    check1({tag, ".rs2Busy"}, 32'(rs2Busy), 32'(b));
    check1({tag, ".rs2RobId"}, 32'(rs2RobId), 32'(t));
    check1({tag, ".rs2Val"}, rs2Val, v);
  endtask

  task automatic tick();
    @(posedge clockIn);
    model_edge();
    #1;
  endtask

  task automatic idle();
    readyIn    = 1'b1;
    clear      = 1'b0;
    renameFlag = 1'b0;
    renameDest = '0;
    renameRobId = '0;
    rfFlag     = 1'b0;
    rfRobId    = '0;
    rfDest     = '0;
    rfValue    = '0;
  endtask

  task automatic ren(input logic [4:0] d, input logic [RW-1:0] id);
    renameFlag  = 1'b1;
    renameDest  = d;
    renameRobId = id;
  endtask

  task automatic cmt(input logic [4:0] d, input logic [RW-1:0] id,
                     input logic [31:0] v);
    rfFlag  = 1'b1;
    rfDest  = d;
    rfRobId = id;
    rfValue = v;
  endtask

  initial begin
    resetIn = 1'b0;
    rs1Addr = 5'd5;
    rs2Addr = 5'd8;
    idle();
    model_reset();
    #2;
    chk("reset");
    check1("reset.x5val", rs1Val, 32'h0);
    @(negedge clockIn);
    resetIn = 1'b1;
    tick();

    ren(5'd5, 4'd3);
    tick();
    idle();
    cmt(5'd5, 4'd3, 32'hDEADBEEF);
    chk("commit_pre");
    tick();
    idle();
    chk("commit_post");
    check1("x5.busy", 32'(rs1Busy), 32'd0);
    check1("x5.val", rs1Val, 32'hDEADBEEF);

    ren(5'd5, 4'd3);
    tick();
    ren(5'd5, 4'd7);
    tick();
    idle();
    cmt(5'd5, 4'd3, 32'h11);
    tick();
    idle();
    chk("stale_commit");
    check1("stale.busy", 32'(rs1Busy), 32'd1);
    check1("stale.tag", 32'(rs1RobId), 32'd7);
    check1("stale.val", rs1Val, 32'h11);
    cmt(5'd5, 4'd7, 32'h22);
    tick();
    idle();
    chk("young_commit");
    check1("young.val", rs1Val, 32'h22);

    ren(5'd8, 4'd1);
    tick();
    idle();
    ren(5'd8, 4'd2);
    cmt(5'd8, 4'd1, 32'h55);
    chk("same_cycle_pre");
    tick();
    idle();
    chk("same_cycle");
    check1("x8.busy", 32'(rs2Busy), 32'd1);
    check1("x8.tag", 32'(rs2RobId), 32'd2);
    check1("x8.val", rs2Val, 32'h55);

    for (int i = 1; i <= 3; i++) begin
      idle();
      cmt(5'(i), 4'd0, 32'hA0 + 32'(i));
      tick();
    end
    for (int i = 1; i <= 3; i++) begin
      idle();
      ren(5'(i), 4'(i + 8));
      tick();
    end
    idle();
    rs1Addr = 5'd1;
    rs2Addr = 5'd4;
    readyIn = 1'b0;
    clear = 1'b1;
    ren(5'd4, 4'd6);
    tick();
    idle();
    chk("clear_notready");
    check1("nr.x1busy", 32'(rs1Busy), 32'd1);
    clear = 1'b1;
    ren(5'd4, 4'd6);
    tick();
    idle();
    chk("clear_x1x4");
    check1("clr.x4busy", 32'(rs2Busy), 32'd0);
    check1("clr.x1val", rs1Val, 32'hA1);
    rs1Addr = 5'd2;
    rs2Addr = 5'd3;
    chk("clear_x2x3");

    rs1Addr = 5'd0;
    cmt(5'd0, 4'd0, 32'hFF);
    ren(5'd0, 4'd5);
    tick();
    idle();
    chk("x0");
    check1("x0.val", rs1Val, 32'h0);

    ren(5'd9, 4'd4);
    tick();
    idle();
    rs1Addr = 5'd9;
    cmt(5'd9, 4'd4, 32'h77);
    chk("bypass");
`ifdef REGFILE_COMMIT_BYPASS_EN
    check1("byp.busy", 32'(rs1Busy), 32'd0);
    check1("byp.val", rs1Val, 32'h77);
`else
    check1("nobyp.busy", 32'(rs1Busy), 32'd1);
`endif
    ren(5'd9, 4'd5);
    chk("bypass_suppressed");
    tick();
    idle();
    chk("after_bypass");

    for (int c = 0; c < 400; c++) begin
      logic [4:0] d;
      readyIn = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 24) == 0);
      renameFlag = $urandom_range(0, 1) == 1;
      renameDest = 5'($urandom_range(0, 7));
      renameRobId = 4'($urandom);
      d = 5'($urandom_range(0, 7));
      rfFlag = $urandom_range(0, 1) == 1;
      rfDest = d;
      rfRobId = $urandom_range(0, 2) != 0 ? m_tag[d] : 4'($urandom);
      rfValue = $urandom;
      rs1Addr = $urandom_range(0, 2) == 0 ? d : 5'($urandom_range(0, 7));
      rs2Addr = 5'($urandom_range(0, 7));
      chk("rand");
      tick();
    end

    idle();
    rs1Addr = 5'd5;
    rs2Addr = 5'd8;
    @(negedge clockIn);
    resetIn = 1'b0;
    model_reset();
    chk("midrun_reset");
    check1("mr.x5val", rs1Val, 32'h0);
    check1("mr.x8busy", 32'(rs2Busy), 32'd0);
    #3;
    resetIn = 1'b1;
    tick();
    chk("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file with rename tags for the out-of-order core. It sits directly downstream of the reorder buffer: it consumes the ROB commit stream (rfFlag/rfRobId/rfDest/rfValue), holds the 32 architectural values, and records which ROB entry will produce each register. The instruction unit reads it at dispatch to get an operand value or the ROB id to wait on, and marks destinations busy when it allocates a ROB entry.

## Interface
Parameters:
- ROB_WIDTH, 4, ROB index width; must match the reorder buffer.

Ports:
- clockIn  input  1  clock; all state updates on rising edge.
- resetIn  input  1  asynchronous, active-low reset.
- readyIn  input  1  global advance enable; state holds when low.
- clear  input  1  mispredict flush from ROB; acts only when readyIn is high.
- renameFlag  input  1  instruction unit allocates a ROB entry that writes a register.
- renameDest  input  5  destination register of that allocation.
- renameRobId  input  ROB_WIDTH  ROB id of that allocation; equals ROB freeId.
- rfFlag  input  1  ROB commit write.
- rfRobId  input  ROB_WIDTH  ROB id being committed.
- rfDest  input  5  committed destination register.
- rfValue  input  32  committed value.
- rs1Addr, rs2Addr  input  5  source register indices.
- rs1Busy, rs2Busy  output  1  source awaits an in-flight ROB entry.
- rs1RobId, rs2RobId  output  ROB_WIDTH  producing ROB id; valid when busy.
- rs1Val, rs2Val  output  32  architectural value; valid when not busy.

## Operation
- State per register: value[31:0], busy, tag[ROB_WIDTH-1:0]. x0 has no state.
- Reads are combinational from current state. x0 always reads busy=0, value=0, tag=0.
- Rename (renameFlag & readyIn & ~clear, dest≠0): busy[dest]←1, tag[dest]←renameRobId. A later rename to the same register overwrites the tag.
- Commit (rfFlag & readyIn, dest≠0): value[dest]←rfValue unconditionally. busy[dest]←0 only if tag[dest]==rfRobId, which means no younger rename is pending.
- Rename and commit to the same register in one cycle: the value is written, and busy=1 with the new tag. Rename always wins the busy/tag fields.
- Clear (clear & readyIn): every busy bit is set to 0 and tags are zeroed. Values are retained. A commit in the same cycle still writes its value. A rename in the same cycle is dropped.
- readyIn low: rename, commit and clear are all ignored. Outputs still track the read addresses.
- Reset (resetIn low, asynchronous): all values 0, busy 0, tags 0. Outputs read as 0/not busy immediately.

## Timing
- Read latency: 0 cycles (combinational). Updates become visible the cycle after the edge.
- Commit arrives one cycle after the ROB head advances. The ROB slot may already be reallocated by then, so a same-cycle read of a committing register must not depend on the ROB (see Configuration).
- No backpressure. Every qualified rename and commit is accepted.

## Configuration
- REGFILE_COMMIT_BYPASS_EN defined: when rfFlag is high and rsNAddr==rfDest (≠0) and tag matches rfRobId, read port N returns busy=0 and value=rfValue in the same cycle.
- Bypass is suppressed if renameFlag targets the same register in that cycle; the read then reflects pre-edge state.
- REGFILE_COMMIT_BYPASS_EN undefined: reads reflect registered state only, and the instruction unit stalls dispatch one cycle on any busy operand whose tag equals rfRobId while rfFlag is high.

## Structure
- Shared package: ROB_WIDTH default, REG_COUNT=32, REG_ADDR_W=5, XLEN=32, ZERO_REG=0.
- One sub-module, register_file_read_port: zero-register handling and the optional bypass mux for one port. It is instantiated twice (rs1, rs2).

## Test plan
- Reset mid-run after several writes -> all reads 0/not busy immediately on resetIn low, before any clock edge.
- Rename x5 tag 3, then commit x5 id 3 value 0xDEADBEEF -> x5 reads busy=0, value 0xDEADBEEF the cycle after the commit.
- Rename x5 tag 3, rename x5 tag 7, commit id 3 value 0x11 -> value 0x11 stored, busy=1, rs1RobId=7. Commit id 7 value 0x22 -> busy=0, value 0x22.
- Same-cycle rename x8 tag 2 and commit x8 id 1 (old tag 1) value 0x55 -> next cycle busy=1, tag=2, value 0x55.
- Rename x1, x2, x3, then clear with readyIn=1 and a same-cycle rename x4 -> all busy 0, x4 not renamed, old values intact. The same sequence with readyIn=0 changes nothing.
- Write/rename x0 -> x0 reads value 0, busy 0. With REGFILE_COMMIT_BYPASS_EN, a same-cycle commit x9 id 4 value 0x77 to a busy x9 tag 4 reads busy=0, value 0x77 combinationally.
